// File: rtl/rr_mux_arbiter_4.sv
// rr_mux_arbiter_4: four-input arbiter driving a 4:1 data mux and
// a single-entry registered output stage with valid/ready.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   in_valid/in_ready - per-requester handshake, bit i <-> d<i>
//   d0..d3            - requester data words (WIDTH bits)
//   sel               - combinational grant index (0 when idle)
//   out_valid/ready   - consumer handshake for the output register
//   out_data/out_src  - registered word and the index that supplied it
//
// Config macro RR_MUX_ARBITER_ROUND_ROBIN_EN: defined selects
// round-robin search from ptr+1; undefined selects fixed priority
// with index 0 highest.
module rr_mux_arbiter_4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       in_valid,
    output logic [3:0]       in_ready,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [1:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_src
);

    logic [1:0]       ptr_q, ptr_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [1:0]       out_src_q, out_src_d;

    logic [1:0]       start;
    logic [1:0]       idx;
    logic             gnt_vld;
    logic [1:0]       gnt_idx;
    logic             accept;
    logic             xfer;
    logic [WIDTH-1:0] sel_data;

`ifdef RR_MUX_ARBITER_ROUND_ROBIN_EN
    assign start = ptr_q + 2'd1;
`else
    // ptr still tracks the last grant but never steers the search.
    logic unused_ptr;
    assign unused_ptr = ^ptr_q;
    assign start      = 2'd0;
`endif

    // Walk the search order backwards so the earliest hit is
    // the last one written and therefore wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = 2'd0;
        idx     = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (in_valid[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    assign accept   = !out_valid_q || out_ready;
    assign xfer     = accept && gnt_vld;
    assign in_ready = xfer ? (4'b0001 << gnt_idx) : 4'b0000;
    assign sel      = gnt_idx;

    always_comb begin
        sel_data = d0;
        unique case (gnt_idx)
            2'd0: sel_data = d0;
            2'd1: sel_data = d1;
            2'd2: sel_data = d2;
            2'd3: sel_data = d3;
        endcase
    end

    // A load takes precedence over a drain, so a word drained in
    // the same cycle is replaced without a bubble.
    always_comb begin
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        if (xfer) begin
            ptr_d       = gnt_idx;
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_src_d   = gnt_idx;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= 2'd3;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 2'd0;
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_rr_mux_arbiter_4.sv
// Bench for rr_mux_arbiter_4: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_rr_mux_arbiter_4;

`ifdef RR_MUX_ARBITER_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in_valid;
    logic [3:0] in_ready;
    logic [3:0] d0, d1, d2, d3;
    logic [1:0] sel;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic [1:0] out_src;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Model state: last grant, and contents of the output register.
    int         m_ptr = 3;
    bit         m_ov  = 1'b0;
    logic [3:0] m_od  = 4'd0;
    int         m_os  = 0;

    rr_mux_arbiter_4 #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .d0       (d0),
        .d1       (d1),
        .d2       (d2),
        .d3       (d3),
        .sel      (sel),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_src  (out_src)
    );

    always #5 clk = ~clk;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     nm, $time, act, exp);
        end
    endtask

    // First valid index in search order; -1 when nothing is valid.
    function automatic int mgrant(logic [3:0] v, int p);
        int s;
        s = RR ? (p + 1) % 4 : 0;
        for (int k = 0; k < 4; k++)
            if (v[(s + k) % 4]) return (s + k) % 4;
        return -1;
    endfunction

    function automatic logic [3:0] mword(int i);
        case (i)
            0: return d0;
            1: return d1;
            2: return d2;
            default: return d3;
        endcase
    endfunction

    int  u_g;
    bit  u_acc;
    always @(posedge clk) begin
        if (rst) begin
            m_ptr = 3; m_ov = 1'b0; m_od = 4'd0; m_os = 0;
        end else begin
            u_acc = !m_ov || out_ready;
            u_g   = mgrant(in_valid, m_ptr);
            if (u_acc && u_g >= 0) begin
                m_od = mword(u_g); m_os = u_g;
                m_ov = 1'b1; m_ptr = u_g;
            end else if (m_ov && out_ready) begin
                m_ov = 1'b0;
            end
        end
    end

    int         c_g;
    logic [3:0] c_rdy;
    always @(negedge clk) begin
        if (chk_en) begin
            c_g   = mgrant(in_valid, m_ptr);
            c_rdy = ((!m_ov || out_ready) && c_g >= 0) ? 4'(1 << c_g) : 4'd0;
            check("m_out_valid", 32'(out_valid), 32'(m_ov));
            check("m_out_data", 32'(out_data), 32'(m_od));
            check("m_out_src", 32'(out_src), 32'(m_os));
            check("m_sel", 32'(sel), 32'(c_g < 0 ? 0 : c_g));
            check("m_in_ready", 32'(in_ready), 32'(c_rdy));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        d0 = 4'd1; d1 = 4'd2; d2 = 4'd3; d3 = 4'd4;
        step();
        chk_en = 1'b1;
        step();
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_src", 32'(out_src), 32'd0);

        // Round robin over all four, first grant is input 0.
        step();
        rst = 1'b0;
        @(negedge clk);
        check("first_ready", 32'(in_ready), 32'b0001);
        check("first_sel", 32'(sel), 32'd0);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("rr_valid", 32'(out_valid), 32'd1);
            check("rr_src", 32'(out_src), 32'(RR ? k % 4 : 0));
            check("rr_data", 32'(out_data), 32'(RR ? k % 4 + 1 : 1));
        end

        // Drain, then a lone requester on input 2.
        #1 in_valid = 4'b0000;
        step();
        in_valid = 4'b0100; d2 = 4'hA;
        @(negedge clk);
        check("single_ready", 32'(in_ready), 32'b0100);
        check("single_sel", 32'(sel), 32'd2);
        step();
        // ptr is now 2: input 1 wins by wrapping past 3 and 0.
        in_valid = 4'b0010;
        @(negedge clk);
        check("single_data", 32'(out_data), 32'hA);
        check("single_src", 32'(out_src), 32'd2);
        check("wrap_sel", 32'(sel), 32'd1);
        check("wrap_ready", 32'(in_ready), 32'b0010);
        step();
        in_valid = 4'b1001;
        @(negedge clk);
        check("skip_sel", 32'(sel), 32'(RR ? 3 : 0));
        step();

        // Backpressure with a full register.
        out_ready = 1'b0; in_valid = 4'b0011;
        d0 = 4'd5; d1 = 4'd6;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_ready", 32'(in_ready), 32'd0);
            check("bp_data", 32'(out_data), 32'(RR ? 4 : 1));
            check("bp_src", 32'(out_src), 32'(RR ? 3 : 0));
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release", 32'(in_ready), 32'b0001);
        step();
        @(negedge clk);
        check("bp_new_data", 32'(out_data), 32'd5);
        check("bp_new_src", 32'(out_src), 32'd0);

        // Reset with a full register and a pending transfer.
        #1 in_valid = 4'b0100; rst = 1'b1;
        step();
        rst = 1'b0; in_valid = 4'b1111;
        @(negedge clk);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'b0001);
        step();
        @(negedge clk);
        check("mid_rst_src", 32'(out_src), 32'd0);

        // Random traffic, model-checked every cycle.
        for (int n = 0; n < 600; n++) begin
            step();
            in_valid  = 4'($urandom);
            d0 = 4'($urandom); d1 = 4'($urandom);
            d2 = 4'($urandom); d3 = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 49) == 0);
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
